// File: rtl/mdu_hilo.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// The result is computed at the start edge and held; hi/lo commit after the busy period.
module mdu_hilo #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cycles
        $error("mdu_hilo: MULT_CYCLES and DIV_CYCLES must be at least 1");
    end

    logic [0:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [63:0]     res_q, res_d;
    logic            div_zero_q, div_zero_d;
    logic            done_q, done_d;

    // Arithmetic datapath, evaluated from the live operands at the start edge
    logic        is_signed_div;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quot, rem;
    logic [63:0] prod_s, prod_u;

    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
    end

    always_comb begin
        is_signed_div = (op == OpDiv);
        a_neg         = is_signed_div & a[31];
        b_neg         = is_signed_div & b[31];
        a_mag         = a_neg ? (~a + 32'd1) : a;
        b_mag         = b_neg ? (~b + 32'd1) : b;
        if (b_mag == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        // Quotient truncates toward zero; remainder follows the dividend's sign
        quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        res_d      = res_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        if (state_q == StIdle) begin
            if (start) begin
                case (op)
                    OpMult, OpMultu: begin
                        res_d      = (op == OpMult) ? prod_s : prod_u;
                        div_zero_d = 1'b0;
                        cnt_d      = CntW'(MULT_CYCLES);
                        state_d    = StBusy;
                    end
                    OpDiv, OpDivu: begin
                        res_d      = {rem, quot};
                        div_zero_d = (b == 32'd0);
                        cnt_d      = CntW'(DIV_CYCLES);
                        state_d    = StBusy;
                    end
                    OpMthi:  hi_d = a;
                    OpMtlo:  lo_d = a;
                    default: ;
                endcase
            end
        end else begin
            if (cnt_q == CntW'(1)) begin
                if (!div_zero_q) begin
                    hi_d = res_q[63:32];
                    lo_d = res_q[31:0];
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            res_q      <= 64'd0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            res_q      <= res_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q == StBusy);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: arithmetic results, busy length, done pulse,
// MTHI/MTLO, start-while-busy and asynchronous reset mid-operation.
module tb_mdu_hilo;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    mdu_hilo #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        step();
        start = 1'b0;
    endtask

    // Issue a long op, measure busy length, then check the commit and one-cycle done
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input int ncyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        issue(o, va, vb);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            step();
        end
        chk({tag, ".cycles"}, 64'(cnt), 64'(ncyc));
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
        step();
        chk({tag, ".done_once"}, 64'(done), 64'd0);
    endtask

    initial begin
        int ndone;
        int nbusy;
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        #12;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("div_7_neg2", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

        issue(3'd4, 32'h11, 32'd0);
        chk("mthi.hi", 64'(hi), 64'h11);
        chk("mthi.busy", 64'(busy), 64'd0);
        chk("mthi.done", 64'(done), 64'd0);
        issue(3'd5, 32'h22, 32'd0);
        chk("mtlo.lo", 64'(lo), 64'h22);
        chk("mtlo.hi", 64'(hi), 64'h11);
        chk("mtlo.busy", 64'(busy), 64'd0);

        issue(3'd6, 32'h5555, 32'd1);
        chk("rsvd.busy", 64'(busy), 64'd0);
        chk("rsvd.hi", 64'(hi), 64'h11);
        chk("rsvd.lo", 64'(lo), 64'h22);

        run_op("div0", 3'd2, 32'd100, 32'd0, 10, 32'h11, 32'h22);
        run_op("divu0", 3'd3, 32'd100, 32'd0, 10, 32'h11, 32'h22);

        // Start MULT at edge t; MTLO at t+2 and DIV at t+3 must be ignored
        issue(3'd0, 32'd3, 32'd4);
        step();
        issue(3'd5, 32'hABCD, 32'd0);
        chk("ign.lo_kept", 64'(lo), 64'h22);
        chk("ign.busy2", 64'(busy), 64'd1);
        issue(3'd2, 32'd100, 32'd7);
        step();
        chk("ign.busy4", 64'(busy), 64'd1);
        step();
        chk("ign.busy5", 64'(busy), 64'd0);
        chk("ign.done", 64'(done), 64'd1);
        chk("ign.hi", 64'(hi), 64'd0);
        chk("ign.lo", 64'(lo), 64'd12);
        step();
        chk("ign.no_div", 64'(busy), 64'd0);
        chk("ign.done_once", 64'(done), 64'd0);

        // Asynchronous reset four cycles into a DIV, away from any clock edge
        issue(3'd2, 32'd100, 32'd7);
        step();
        step();
        step();
        #3;
        reset = 1'b0;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.hi", 64'(hi), 64'd0);
        chk("arst.lo", 64'(lo), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) ndone++;
            if (busy) nbusy++;
        end
        chk("arst.no_done", 64'(ndone), 64'd0);
        chk("arst.idle", 64'(nbusy), 64'd0);

        run_op("post_rst", 3'd1, 32'h1_0000, 32'h1_0000, 5, 32'd1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
